// File: rtl/ticket_dispatcher_if.sv
// Ticket dispatcher bus: button and counter enables in, queue/counter state out.
// master drives button/counter_enable; slave (the dispatcher) drives the rest.
interface ticket_dispatcher_if #(
   parameter int NUM_COUNTERS = 5,
   parameter int TICKET_W     = 6,
   parameter int QUEUE_DEPTH  = 8
);
   localparam int QCW = $clog2(QUEUE_DEPTH) + 1;
   localparam int CIW = ($clog2(NUM_COUNTERS) > 1) ? $clog2(NUM_COUNTERS) : 1;

   logic                             button;
   logic [NUM_COUNTERS-1:0]          counter_enable;
   logic [TICKET_W-1:0]              issued_number;
   logic [QCW-1:0]                   queue_count;
   logic                             queue_full;
   logic                             drop;
   logic [NUM_COUNTERS-1:0]          busy;
   logic                             call_valid;
   logic [CIW-1:0]                   counter_call;
   logic [NUM_COUNTERS*TICKET_W-1:0] service_number;
   logic [15:0]                      served_total;

   modport master (
      output button, counter_enable,
      input  issued_number, queue_count, queue_full, drop,
      input  busy, call_valid, counter_call, service_number, served_total
   );

   modport slave (
      input  button, counter_enable,
      output issued_number, queue_count, queue_full, drop,
      output busy, call_valid, counter_call, service_number, served_total
   );
endinterface

// File: rtl/ticket_dispatcher.sv
// Queue-ticket dispatcher: button presses issue tickets into a FIFO, which are
// handed to the lowest free enabled counter. Ports: clk, rst (async, low), bus.
module ticket_dispatcher #(
   parameter int NUM_COUNTERS   = 5,
   parameter int TICKET_W       = 6,
   parameter int QUEUE_DEPTH    = 8,
   parameter int SERVICE_CYCLES = 8
) (
   input logic                clk,
   input logic                rst,
   ticket_dispatcher_if.slave bus
);
   localparam int PW  = $clog2(QUEUE_DEPTH);
   localparam int QCW = PW + 1;
   localparam int CIW = ($clog2(NUM_COUNTERS) > 1) ? $clog2(NUM_COUNTERS) : 1;
   localparam int TW  = $clog2(SERVICE_CYCLES);
   localparam logic [TICKET_W-1:0] MAX_TICKET = '1;
   localparam logic [TW-1:0] TIMER_LOAD = TW'(SERVICE_CYCLES - 1);

   logic                             b1, b2;
   logic                             press;
   logic [TICKET_W-1:0]              mem [QUEUE_DEPTH];
   logic [PW-1:0]                    rdPtr, wrPtr;
   logic [QCW-1:0]                   count;
   logic [TICKET_W-1:0]              issued, nextTicket, head;
   logic [NUM_COUNTERS-1:0]          busy;
   logic [TW-1:0]                    timer [NUM_COUNTERS];
   logic [NUM_COUNTERS*TICKET_W-1:0] svc;
   logic [CIW-1:0]                   winIdx, callIdx;
   logic                             winFound, doPop, doPush, isFull;
   logic                             callValid, dropQ;
   logic [15:0]                      served;

   assign press      = b1 & ~b2;
   assign isFull     = (count == QCW'(QUEUE_DEPTH));
   assign head       = mem[rdPtr];
   assign nextTicket = (issued == MAX_TICKET) ? TICKET_W'(1)
                                              : issued + TICKET_W'(1);

   // Scan downwards so the lowest eligible index is the last one written.
   always_comb begin
      winFound = 1'b0;
      winIdx   = '0;
      for (int i = NUM_COUNTERS - 1; i >= 0; i--) begin
         if (!busy[i] && bus.counter_enable[i]) begin
            winFound = 1'b1;
            winIdx   = CIW'(i);
         end
      end
   end

   // Dispatch looks at the registered count, so a ticket pushed this edge
   // waits one cycle; a same-edge pop frees a slot for a push when full.
   assign doPop  = winFound && (count != '0);
   assign doPush = press && (!isFull || doPop);

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= nextTicket;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         b1        <= 1'b0;
         b2        <= 1'b0;
         rdPtr     <= '0;
         wrPtr     <= '0;
         count     <= '0;
         issued    <= '0;
         dropQ     <= 1'b0;
         callValid <= 1'b0;
         callIdx   <= '0;
         served    <= '0;
      end else begin
         b1        <= bus.button;
         b2        <= b1;
         dropQ     <= press && !doPush;
         callValid <= doPop;
         if (doPush) begin
            wrPtr  <= wrPtr + PW'(1);
            issued <= nextTicket;
         end
         if (doPop) begin
            rdPtr   <= rdPtr + PW'(1);
            callIdx <= winIdx;
            if (served != 16'hFFFF) served <= served + 16'd1;
         end
         unique case ({doPush, doPop})
            2'b10:   count <= count + QCW'(1);
            2'b01:   count <= count - QCW'(1);
            default: count <= count;
         endcase
      end
   end

   // Timer counts SERVICE_CYCLES-1 down to 0; busy drops on the edge at 0,
   // so busy is high for exactly SERVICE_CYCLES cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= '0;
         svc  <= '0;
         for (int i = 0; i < NUM_COUNTERS; i++) timer[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (busy[i]) begin
               if (timer[i] == '0) busy[i] <= 1'b0;
               else timer[i] <= timer[i] - TW'(1);
            end else if (doPop && (winIdx == CIW'(i))) begin
               busy[i]                    <= 1'b1;
               timer[i]                   <= TIMER_LOAD;
               svc[i*TICKET_W +: TICKET_W] <= head;
            end
         end
      end
   end

   assign bus.issued_number  = issued;
   assign bus.queue_count    = count;
   assign bus.queue_full     = isFull;
   assign bus.drop           = dropQ;
   assign bus.busy           = busy;
   assign bus.call_valid     = callValid;
   assign bus.counter_call   = callIdx;
   assign bus.service_number = svc;
   assign bus.served_total   = served;
endmodule
